sram_like_arbiter: RTL and testbench
====================================

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 inst_req  in  1  instruction read request; held until inst_addr_ok.
REQ-004 inst_addr  in  32  instruction fetch address.
REQ-005 inst_addr_ok  out  1  instruction address accepted.
REQ-006 inst_data_ok  out  1  instruction read data valid.
REQ-007 inst_rdata  out  32  instruction read data.
REQ-008 data_req  in  1  data request; held until data_addr_ok.
REQ-009 data_wr  in  1  1 = write, 0 = read.
REQ-010 data_size  in  2  0 = byte, 1 = half, 2 = word.
REQ-011 data_addr  in  32  data address.
REQ-012 data_wdata  in  32  write data.
REQ-013 data_addr_ok  out  1  data address accepted.
REQ-014 data_data_ok  out  1  data transaction complete; rdata valid for reads.
REQ-015 data_rdata  out  32  data read data.
REQ-016 m_req  out  1  shared-port request.
REQ-017 m_wr  out  1  shared-port write flag.
REQ-018 m_size  out  2  shared-port size.
REQ-019 m_addr  out  32  shared-port address.
REQ-020 m_wdata  out  32  shared-port write data.
REQ-021 m_addr_ok  in  1  slave accepted address.
REQ-022 m_data_ok  in  1  slave data response.
REQ-023 m_rdata  in  32  slave read data.

Function
REQ-024 The block SHALL arbitrate the instruction and data sram-like requesters onto one sram-like master port, with at most one outstanding transaction.
REQ-025 The FSM SHALL have exactly three states:
- IDLE
- ADDR (m_req=1)
- WAIT (awaiting m_data_ok)
REQ-026 In IDLE with any request pending, the FSM SHALL latch the winner's wr/size/addr/wdata into registers, record the owner, and enter ADDR on the next cycle.
- This gives one cycle of arbitration latency.
- Instruction grants SHALL latch wr=0, size=2, wdata=0.
REQ-027 Priority SHALL be data over instruction, except that when both requests are pending and the previous grant went to data, instruction SHALL win.
- This gives strict alternation under contention, so neither requester starves.
REQ-028 m_wr, m_size, m_addr and m_wdata SHALL be driven from the latched registers and SHALL be stable for the whole of ADDR.
REQ-029 In ADDR, m_addr_ok=1 SHALL pulse the owner's addr_ok for that cycle only.
- If m_data_ok=0 in the same cycle, the FSM SHALL enter WAIT.
- If m_data_ok=1 in the same cycle, the owner's data_ok SHALL also pulse and the FSM SHALL return to IDLE.
REQ-030 In WAIT, m_data_ok=1 SHALL pulse the owner's data_ok, pass m_rdata combinationally to the owner's rdata, and return the FSM to IDLE.
REQ-031 The non-owner's addr_ok and data_ok SHALL be 0 at all times.
- The non-owner's rdata SHALL hold its last delivered value.
REQ-032 m_addr_ok or m_data_ok arriving in a state that does not expect it SHALL be ignored and SHALL produce no requester pulse.
- m_addr_ok is unexpected in IDLE and WAIT.
- m_data_ok is unexpected in IDLE.
REQ-033 A requester that drops its request before grant SHALL NOT be granted; a request that is already latched SHALL complete regardless.
REQ-034 Back-to-back transactions SHALL be permitted: a new grant MAY be latched in the same cycle the FSM leaves WAIT or ADDR for IDLE.
- Minimum spacing between grants is 2 cycles.

Reset
REQ-035 On rst=1 at a clock edge, the block SHALL reset to this state, abandoning any in-flight transaction without generating requester pulses:
- FSM = IDLE
- m_req = 0, m_wr = 0, m_size = 0, m_addr = 0, m_wdata = 0
- all addr_ok/data_ok outputs = 0, both rdata outputs = 0
- the last-grant record set to instruction, so data wins the first contention

Verification
REQ-036 Scenario 1, data read: data_req=1, wr=0, addr=0x8000_0010; slave gives addr_ok 1 cycle after m_req and data_ok 2 cycles later with rdata 0x1234_5678.
- m_req asserts 1 cycle after data_req.
- data_addr_ok and data_data_ok each pulse exactly once.
- data_rdata = 0x1234_5678.
- inst_* outputs stay 0.
REQ-037 Scenario 2, contention: inst_req and data_req held continuously.
- Grant order: D, I, D, I.
- m_addr alternates between the data and instruction addresses.
REQ-038 Scenario 3, combined handshake: m_addr_ok and m_data_ok asserted in the same ADDR cycle for an instruction fetch.
- inst_addr_ok and inst_data_ok pulse in that one cycle.
- The FSM returns to IDLE.
- WAIT is never entered.
REQ-039 Scenario 4, reset mid-operation: rst pulsed while in WAIT, then a late m_data_ok.
- No data_ok is produced for either requester.
- All outputs read 0 after reset.
- The late m_data_ok is ignored.
REQ-040 Scenario 5, data write: data_wr=1, size=1, addr=0xBFAF_0002, wdata=0xAAAA_5555; data_addr changed after addr_ok.
- m_wr=1, m_size=1, m_addr=0xBFAF_0002 and m_wdata=0xAAAA_5555 are held throughout ADDR.
- The later change to data_addr does not affect the transaction.

Source files
------------

// File: rtl/sram_like_arbiter_if.sv
// Sram-like request/response bundle shared by the instruction, data and memory sides of the arbiter.
// The requester drives the master modport and the responder drives the slave modport.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-requester sram-like arbiter: instruction and data ports share one memory port,
// with at most one transaction in flight and alternating grants under contention.
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winner's request
// ADDR  | m_req high with latched wr/size/addr/wdata, waiting for m_addr_ok
// WAIT  | address accepted, waiting for m_data_ok
module sram_like_arbiter (
  input logic                clk,
  input logic                rst,
  sram_like_arbiter_if.slave  inst,
  sram_like_arbiter_if.slave  data,
  sram_like_arbiter_if.master m
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_data_q, owner_data_d;
  logic        last_data_q, last_data_d;
  logic        m_req_q, m_req_d;
  logic        m_wr_q, m_wr_d;
  logic [1:0]  m_size_q, m_size_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic addr_hit;
  logic done_hit;
  logic pick_data;
  logic addr_pulse;
  logic done_pulse;

  // Data normally wins; instruction wins a tie only when data took the previous grant.
  assign pick_data = data.req && !(inst.req && last_data_q);

  assign addr_hit = (state_q == ADDR) && m.addr_ok;
  assign done_hit = (addr_hit && m.data_ok) || ((state_q == WAIT) && m.data_ok);

  // Pulses are suppressed while rst is high so an abandoned transaction never completes.
  assign addr_pulse = addr_hit && !rst;
  assign done_pulse = done_hit && !rst;

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    last_data_d  = last_data_q;
    m_req_d      = m_req_q;
    m_wr_d       = m_wr_q;
    m_size_d     = m_size_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_data) begin
          owner_data_d = 1'b1;
          last_data_d  = 1'b1;
          m_wr_d       = data.wr;
          m_size_d     = data.size;
          m_addr_d     = data.addr;
          m_wdata_d    = data.wdata;
          m_req_d      = 1'b1;
          state_d      = ADDR;
        end else if (inst.req) begin
          owner_data_d = 1'b0;
          last_data_d  = 1'b0;
          m_wr_d       = 1'b0;
          m_size_d     = 2'd2;
          m_addr_d     = inst.addr;
          m_wdata_d    = 32'd0;
          m_req_d      = 1'b1;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        if (m.addr_ok) begin
          m_req_d = 1'b0;
          state_d = m.data_ok ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (m.data_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        m_req_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (done_hit) begin
      if (owner_data_q) begin
        data_rdata_d = m.rdata;
      end else begin
        inst_rdata_d = m.rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      last_data_q  <= 1'b0;
      m_req_q      <= 1'b0;
      m_wr_q       <= 1'b0;
      m_size_q     <= 2'd0;
      m_addr_q     <= 32'd0;
      m_wdata_q    <= 32'd0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      last_data_q  <= last_data_d;
      m_req_q      <= m_req_d;
      m_wr_q       <= m_wr_d;
      m_size_q     <= m_size_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign m.req   = m_req_q;
  assign m.wr    = m_wr_q;
  assign m.size  = m_size_q;
  assign m.addr  = m_addr_q;
  assign m.wdata = m_wdata_q;

  assign inst.addr_ok = addr_pulse && !owner_data_q;
  assign data.addr_ok = addr_pulse && owner_data_q;
  assign inst.data_ok = done_pulse && !owner_data_q;
  assign data.data_ok = done_pulse && owner_data_q;

  // Read data passes straight through on the completing cycle, otherwise holds the last delivery.
  assign inst.rdata = (done_pulse && !owner_data_q) ? m.rdata : inst_rdata_q;
  assign data.rdata = (done_pulse && owner_data_q) ? m.rdata : data_rdata_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: table of single transactions with a scoreboard,
// plus hand sequences for a dropped request, reset during WAIT and contention.
module tb_sram_like_arbiter;

  logic clk;
  logic rst;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if m_if ();

  sram_like_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst_if),
    .data (data_if),
    .m    (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          addr_lat;
    int          data_lat;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    bit          is_data;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } sb_t;

  int          n_chk;
  int          n_fail;
  sb_t         sb_q[$];
  bit          grant_q[$];
  logic [31:0] mdl_inst_rdata;
  logic [31:0] mdl_data_rdata;
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic reset_check(input string tag);
    chk1({tag, "_m_req"}, m_if.req, 1'b0);
    chk1({tag, "_m_wr"}, m_if.wr, 1'b0);
    chk({tag, "_m_size"}, {30'd0, m_if.size}, 32'd0);
    chk({tag, "_m_addr"}, m_if.addr, 32'd0);
    chk({tag, "_m_wdata"}, m_if.wdata, 32'd0);
    chk1({tag, "_inst_addr_ok"}, inst_if.addr_ok, 1'b0);
    chk1({tag, "_inst_data_ok"}, inst_if.data_ok, 1'b0);
    chk1({tag, "_data_addr_ok"}, data_if.addr_ok, 1'b0);
    chk1({tag, "_data_data_ok"}, data_if.data_ok, 1'b0);
    chk({tag, "_inst_rdata"}, inst_if.rdata, 32'd0);
    chk({tag, "_data_rdata"}, data_if.rdata, 32'd0);
  endtask

  task automatic sb_pop_check(input string tag);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk1({tag, "_sb_nonempty"}, 1'b0, 1'b1);
      return;
    end
    e = sb_q.pop_front();
    if (e.is_data) begin
      chk1({tag, "_data_data_ok"}, data_if.data_ok, 1'b1);
      chk({tag, "_data_rdata"}, data_if.rdata, e.exp_rdata);
      chk({tag, "_inst_rdata_hold"}, inst_if.rdata, mdl_inst_rdata);
      mdl_data_rdata = e.exp_rdata;
    end else begin
      chk1({tag, "_inst_data_ok"}, inst_if.data_ok, 1'b1);
      chk({tag, "_inst_rdata"}, inst_if.rdata, e.exp_rdata);
      chk({tag, "_data_rdata_hold"}, data_if.rdata, mdl_data_rdata);
      mdl_inst_rdata = e.exp_rdata;
    end
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    sb_t         e;
    logic [31:0] rd;
    string       tag;
    tag = $sformatf("v%0d", idx);
    // Writes return the current model value so the held read data is unambiguous either way.
    rd = (v.is_data && v.wr) ? mdl_data_rdata : v.rdata;
    e  = '{v.is_data, v.exp_wr, v.exp_size, v.addr, v.exp_wdata, rd};
    sb_q.push_back(e);

    @(negedge clk);
    if (v.is_data) begin
      data_if.req = 1'b1; data_if.wr = v.wr; data_if.size = v.size;
      data_if.addr = v.addr; data_if.wdata = v.wdata;
    end else begin
      inst_if.req = 1'b1; inst_if.wr = v.wr; inst_if.size = v.size;
      inst_if.addr = v.addr; inst_if.wdata = v.wdata;
    end
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0;
    #1;
    chk1({tag, "_idle_m_req"}, m_if.req, 1'b0);

    for (int i = 0; i <= v.addr_lat; i++) begin
      @(negedge clk);
      m_if.addr_ok = (i == v.addr_lat);
      m_if.data_ok = (i == v.addr_lat) && (v.data_lat == 0);
      m_if.rdata   = m_if.data_ok ? rd : 32'hDEAD_0000 + i;
      #1;
      chk1({tag, "_addr_m_req"}, m_if.req, 1'b1);
      chk1({tag, "_addr_m_wr"}, m_if.wr, sb_q[0].exp_wr);
      chk({tag, "_addr_m_size"}, {30'd0, m_if.size}, {30'd0, sb_q[0].exp_size});
      chk({tag, "_addr_m_addr"}, m_if.addr, sb_q[0].exp_addr);
      chk({tag, "_addr_m_wdata"}, m_if.wdata, sb_q[0].exp_wdata);
      chk1({tag, "_own_addr_ok"}, v.is_data ? data_if.addr_ok : inst_if.addr_ok, i == v.addr_lat);
      chk1({tag, "_oth_addr_ok"}, v.is_data ? inst_if.addr_ok : data_if.addr_ok, 1'b0);
      chk1({tag, "_oth_data_ok"}, v.is_data ? inst_if.data_ok : data_if.data_ok, 1'b0);
      if (i == v.addr_lat && v.data_lat == 0) sb_pop_check(tag);
      else chk1({tag, "_own_early_data_ok"}, v.is_data ? data_if.data_ok : inst_if.data_ok, 1'b0);
    end

    for (int j = 1; j <= v.data_lat; j++) begin
      @(negedge clk);
      if (v.is_data) begin
        data_if.req = 1'b0; data_if.addr = ~v.addr; data_if.wdata = ~v.wdata;
      end else begin
        inst_if.req = 1'b0; inst_if.addr = ~v.addr;
      end
      m_if.addr_ok = 1'b0;
      m_if.data_ok = (j == v.data_lat);
      m_if.rdata   = (j == v.data_lat) ? rd : 32'hDEAD_1000 + j;
      #1;
      chk1({tag, "_wait_m_req"}, m_if.req, 1'b0);
      chk1({tag, "_wait_oth_data_ok"}, v.is_data ? inst_if.data_ok : data_if.data_ok, 1'b0);
      chk1({tag, "_wait_own_addr_ok"}, v.is_data ? data_if.addr_ok : inst_if.addr_ok, 1'b0);
      if (j == v.data_lat) sb_pop_check(tag);
      else begin
        chk1({tag, "_wait_own_data_ok"}, v.is_data ? data_if.data_ok : inst_if.data_ok, 1'b0);
        chk({tag, "_wait_own_rdata"}, v.is_data ? data_if.rdata : inst_if.rdata,
            v.is_data ? mdl_data_rdata : mdl_inst_rdata);
      end
    end

    // Back in IDLE: stray handshakes must be ignored.
    @(negedge clk);
    inst_if.req = 1'b0; data_if.req = 1'b0;
    m_if.addr_ok = 1'b1; m_if.data_ok = 1'b1; m_if.rdata = 32'hBAD0_BAD0;
    #1;
    chk1({tag, "_idle_m_req_after"}, m_if.req, 1'b0);
    chk1({tag, "_stray_inst_addr_ok"}, inst_if.addr_ok, 1'b0);
    chk1({tag, "_stray_inst_data_ok"}, inst_if.data_ok, 1'b0);
    chk1({tag, "_stray_data_addr_ok"}, data_if.addr_ok, 1'b0);
    chk1({tag, "_stray_data_data_ok"}, data_if.data_ok, 1'b0);
    chk({tag, "_hold_inst_rdata"}, inst_if.rdata, mdl_inst_rdata);
    chk({tag, "_hold_data_rdata"}, data_if.rdata, mdl_data_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int last_cyc;
    bit exp_d;

    n_chk = 0;
    n_fail = 0;
    mdl_inst_rdata = 32'd0;
    mdl_data_rdata = 32'd0;

    //            data  wr    size  addr           wdata          rdata          al dl  ewr   esz   ewdata
    vecs[0] = '{1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0000_0000, 32'h1234_5678, 1, 2, 1'b0, 2'd2, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b1, 2'd0, 32'hBFC0_0000, 32'h5A5A_5A5A, 32'h2402_0001, 0, 0, 1'b0, 2'd2, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b1, 2'd1, 32'hBFAF_0002, 32'hAAAA_5555, 32'h0000_0000, 3, 1, 1'b1, 2'd1, 32'hAAAA_5555};
    vecs[3] = '{1'b0, 1'b0, 2'd2, 32'hBFC0_0004, 32'h0000_0000, 32'h3C08_BFAF, 0, 3, 1'b0, 2'd2, 32'h0000_0000};
    vecs[4] = '{1'b1, 1'b1, 2'd0, 32'h8000_0103, 32'h0000_00EE, 32'h0000_0000, 2, 0, 1'b1, 2'd0, 32'h0000_00EE};
    vecs[5] = '{1'b1, 1'b0, 2'd1, 32'h8000_0202, 32'h0000_0000, 32'h0000_BEEF, 0, 1, 1'b0, 2'd1, 32'h0000_0000};

    rst = 1'b1;
    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd0; inst_if.addr = 32'd0; inst_if.wdata = 32'd0;
    data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd0; data_if.addr = 32'd0; data_if.wdata = 32'd0;
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0; m_if.rdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    reset_check("por");

    for (int k = 0; k < 6; k++) run_txn(k, vecs[k]);

    // Instruction request raised during a data transaction and dropped before it could be granted.
    @(negedge clk);
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0;
    data_if.req = 1'b1; data_if.wr = 1'b0; data_if.size = 2'd2; data_if.addr = 32'h8000_2000;
    @(negedge clk);
    m_if.addr_ok = 1'b1;
    inst_if.req = 1'b1; inst_if.addr = 32'hBFC0_2000;
    #1;
    chk1("drop_data_addr_ok", data_if.addr_ok, 1'b1);
    chk1("drop_inst_addr_ok", inst_if.addr_ok, 1'b0);
    @(negedge clk);
    m_if.addr_ok = 1'b0; data_if.req = 1'b0; inst_if.req = 1'b0;
    #1;
    chk1("drop_wait_m_req", m_if.req, 1'b0);
    @(negedge clk);
    m_if.data_ok = 1'b1; m_if.rdata = 32'h5555_0001;
    #1;
    chk1("drop_data_data_ok", data_if.data_ok, 1'b1);
    chk("drop_data_rdata", data_if.rdata, 32'h5555_0001);
    mdl_data_rdata = 32'h5555_0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      m_if.data_ok = 1'b0;
      #1;
      chk1($sformatf("drop_no_grant_%0d", c), m_if.req, 1'b0);
    end

    // Reset while in WAIT, then a late m_data_ok.
    @(negedge clk);
    data_if.req = 1'b1; data_if.wr = 1'b0; data_if.size = 2'd2; data_if.addr = 32'h8000_3000;
    @(negedge clk);
    m_if.addr_ok = 1'b1;
    #1;
    chk1("rst_data_addr_ok", data_if.addr_ok, 1'b1);
    @(negedge clk);
    m_if.addr_ok = 1'b0; data_if.req = 1'b0; rst = 1'b1;
    #1;
    chk1("rst_data_data_ok", data_if.data_ok, 1'b0);
    chk1("rst_inst_data_ok", inst_if.data_ok, 1'b0);
    @(negedge clk);
    rst = 1'b0; m_if.data_ok = 1'b1; m_if.rdata = 32'hFFFF_0000;
    #1;
    reset_check("late");
    mdl_inst_rdata = 32'd0;
    mdl_data_rdata = 32'd0;

    // Contention with both requests held: alternation, starting with data after reset.
    grant_q.push_back(1'b1); grant_q.push_back(1'b0);
    grant_q.push_back(1'b1); grant_q.push_back(1'b0);
    @(negedge clk);
    m_if.data_ok = 1'b0;
    data_if.req = 1'b1; data_if.wr = 1'b0; data_if.size = 2'd2; data_if.addr = 32'h8000_1000;
    inst_if.req = 1'b1; inst_if.addr = 32'hBFC0_1000;
    cnt = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 20 && cnt < 4; cyc++) begin
      @(negedge clk);
      m_if.addr_ok = m_if.req;
      m_if.data_ok = m_if.req;
      m_if.rdata   = 32'hC0DE_0000 + cyc;
      #1;
      if (m_if.req) begin
        exp_d = grant_q.pop_front();
        chk1($sformatf("cont%0d_data_addr_ok", cnt), data_if.addr_ok, exp_d);
        chk1($sformatf("cont%0d_inst_addr_ok", cnt), inst_if.addr_ok, !exp_d);
        chk($sformatf("cont%0d_m_addr", cnt), m_if.addr, exp_d ? 32'h8000_1000 : 32'hBFC0_1000);
        chk($sformatf("cont%0d_rdata", cnt), exp_d ? data_if.rdata : inst_if.rdata, 32'hC0DE_0000 + cyc);
        if (cnt > 0) chk($sformatf("cont%0d_spacing", cnt), cyc - last_cyc, 2);
        last_cyc = cyc;
        cnt++;
      end
    end
    chk("cont_grants", cnt, 4);
    @(negedge clk);
    data_if.req = 1'b0; inst_if.req = 1'b0;
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
